// File: rtl/ex_muldiv_unit.sv
// ---------------------------------------------------------------------------
// ex_muldiv_unit
//
// Purpose:
//   Iterative multiply/divide unit that sits next to the ALU in the EX stage.
//   It holds the architectural HI/LO registers. MULT/MULTU/DIV/DIVU run over
//   several cycles, MTHI/MTLO complete in one edge, and MFHI/MFLO are served
//   combinationally. A stall request tells the hazard unit to hold a
//   HI/LO-class instruction that reaches EX while an earlier operation is
//   still running.
//
// Ports:
//   clk       in   1       pipeline clock
//   reset     in   1       asynchronous reset, active low (asserted at 0)
//   in_valid  in   1       EX instruction is a HI/LO-class op
//   in_func   in   6       function code (MFHI 0x10 .. DIVU 0x1B)
//   in_flush  in   1       EX instruction is squashed; suppresses issue/stall
//   op_a      in   DATA_W  rs value (dividend / multiplicand / MTxx source)
//   op_b      in   DATA_W  rt value (divisor / multiplier)
//   mf_data   out  DATA_W  HI for MFHI, LO for MFLO, else 0 (combinational)
//   busy      out  1       multi-cycle operation in progress
//   stall     out  1       hold IF/ID/EX, bubble into EX/MEM
//   hi        out  DATA_W  HI register
//   lo        out  DATA_W  LO register
//
// Parameters:
//   DATA_W    operand and HI/LO width; also the full iteration count
//   DIV0_LO   value written to LO on divide-by-zero
//
// Build option:
//   MULDIV_EARLY_OUT_EN  when defined, MUL stops as soon as the remaining
//                        multiplier bits are zero and divide-by-zero finishes
//                        after one cycle. Results are identical to the
//                        full-latency build, which is the default.
// ---------------------------------------------------------------------------
module ex_muldiv_unit #(
  parameter int                 DATA_W  = 32,
  parameter logic [DATA_W-1:0]  DIV0_LO = {DATA_W{1'b1}}
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [5:0]        in_func,
  input  logic              in_flush,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic [DATA_W-1:0] mf_data,
  output logic              busy,
  output logic              stall,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_e;

  // Architectural and control state
  state_e              state_q, state_d;
  logic [DATA_W-1:0]   hi_q, hi_d;
  logic [DATA_W-1:0]   lo_q, lo_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  // Multiply datapath: running product and left-shifting multiplicand
  logic [2*DATA_W-1:0] acc_q, acc_d;
  logic [2*DATA_W-1:0] mcand_q, mcand_d;

  // Shared: right-shifting multiplier magnitude, or divisor magnitude
  logic [DATA_W-1:0]   opb_q, opb_d;

  // Divide datapath: partial remainder and dividend/quotient shift register
  logic [DATA_W-1:0]   rem_q, rem_d;
  logic [DATA_W-1:0]   quo_q, quo_d;

  // Sign fix-up flags and divide-by-zero bookkeeping
  logic                neg_res_q, neg_res_d;
  logic                neg_rem_q, neg_rem_d;
  logic                div0_q, div0_d;
  logic [DATA_W-1:0]   raw_a_q, raw_a_d;

  // Issue-side decode
  logic                is_signed;
  logic                a_neg;
  logic                b_neg;
  logic [DATA_W-1:0]   a_mag;
  logic [DATA_W-1:0]   b_mag;

  // Per-cycle step results
  logic [2*DATA_W-1:0] mul_sum;
  logic [2*DATA_W-1:0] prod_fix;
  logic [DATA_W:0]     div_trial;
  logic [DATA_W:0]     div_diff;
  logic                div_ge;
  logic [DATA_W-1:0]   rem_next;
  logic [DATA_W-1:0]   quo_next;
  logic [DATA_W-1:0]   quo_fix;
  logic [DATA_W-1:0]   rem_fix;
  logic                last_step;
  logic                mul_done;
  logic                div_done;

  // Only MULT and DIV treat operands as two's complement; the unsigned
  // forms and every other code take the operands as they are.
  always_comb begin
    is_signed = (in_func == F_MULT) || (in_func == F_DIV);
    a_neg     = is_signed & op_a[DATA_W-1];
    b_neg     = is_signed & op_b[DATA_W-1];
    a_mag     = a_neg ? (~op_a + 1'b1) : op_a;
    b_mag     = b_neg ? (~op_b + 1'b1) : op_b;
  end

  // One shift-add step: add the shifted multiplicand when the current
  // multiplier LSB is set. The sign fix-up is applied to the post-step sum
  // so the final edge can write HI/LO directly.
  always_comb begin
    mul_sum  = opb_q[0] ? (acc_q + mcand_q) : acc_q;
    prod_fix = neg_res_q ? (~mul_sum + 1'b1) : mul_sum;
  end

  // One restoring-divide step: bring down the next dividend bit and keep
  // the subtraction only if it did not go negative. The remainder always
  // stays below the divisor, so DATA_W bits are enough to hold it.
  always_comb begin
    div_trial = {rem_q, quo_q[DATA_W-1]};
    div_diff  = div_trial - {1'b0, opb_q};
    div_ge    = ~div_diff[DATA_W];
    rem_next  = div_ge ? div_diff[DATA_W-1:0] : div_trial[DATA_W-1:0];
    quo_next  = {quo_q[DATA_W-2:0], div_ge};
    quo_fix   = neg_res_q ? (~quo_next + 1'b1) : quo_next;
    rem_fix   = neg_rem_q ? (~rem_next + 1'b1) : rem_next;
  end

  // Completion detection. The full-latency build always runs DATA_W steps;
  // the early-out build also stops once no multiplier bits remain, or
  // immediately for a zero divisor whose result does not depend on steps.
`ifdef MULDIV_EARLY_OUT_EN
  logic [DATA_W-1:0] mul_rest;

  always_comb begin
    mul_rest  = opb_q >> 1;
    last_step = (cnt_q == LAST_STEP);
    mul_done  = last_step || (mul_rest == '0);
    div_done  = last_step || div0_q;
  end
`else
  always_comb begin
    last_step = (cnt_q == LAST_STEP);
    mul_done  = last_step;
    div_done  = last_step;
  end
`endif

  // Next-state logic: issue from IDLE, step the datapath in MUL/DIV, and
  // write HI/LO on the final step before returning to IDLE.
  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    opb_d     = opb_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    raw_a_d   = raw_a_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid && !in_flush) begin
          case (in_func)
            F_MTHI: hi_d = op_a;
            F_MTLO: lo_d = op_a;
            F_MULT, F_MULTU: begin
              state_d   = S_MUL;
              cnt_d     = '0;
              acc_d     = '0;
              mcand_d   = {{DATA_W{1'b0}}, a_mag};
              opb_d     = b_mag;
              neg_res_d = a_neg ^ b_neg;
              neg_rem_d = 1'b0;
              div0_d    = 1'b0;
            end
            F_DIV, F_DIVU: begin
              state_d   = S_DIV;
              cnt_d     = '0;
              rem_d     = '0;
              quo_d     = a_mag;
              opb_d     = b_mag;
              neg_res_d = a_neg ^ b_neg;
              neg_rem_d = a_neg;
              div0_d    = (op_b == '0);
              raw_a_d   = op_a;
            end
            default: ;
          endcase
        end
      end

      S_MUL: begin
        acc_d   = mul_sum;
        mcand_d = mcand_q << 1;
        opb_d   = opb_q >> 1;
        cnt_d   = cnt_q + CNT_W'(1);
        if (mul_done) begin
          {hi_d, lo_d} = prod_fix;
          cnt_d        = '0;
          state_d      = S_IDLE;
        end
      end

      S_DIV: begin
        rem_d = rem_next;
        quo_d = quo_next;
        cnt_d = cnt_q + CNT_W'(1);
        if (div_done) begin
          // A zero divisor hands back the raw dividend in HI, unsigned-fixed.
          if (div0_q) begin
            lo_d = DIV0_LO;
            hi_d = raw_a_q;
          end else begin
            lo_d = quo_fix;
            hi_d = rem_fix;
          end
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset aborts any running operation and clears HI/LO.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      hi_q      <= '0;
      lo_q      <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      opb_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      raw_a_q   <= '0;
    end else begin
      state_q   <= state_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      opb_q     <= opb_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      raw_a_q   <= raw_a_d;
    end
  end

  // A squashed instruction never needs to wait, so flush masks the stall.
  always_comb begin
    busy    = (state_q != S_IDLE);
    stall   = in_valid & busy & ~in_flush;
    mf_data = '0;
    if (in_valid) begin
      if (in_func == F_MFHI) mf_data = hi_q;
      else if (in_func == F_MFLO) mf_data = lo_q;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_ex_muldiv_unit
//
// Directed testbench for ex_muldiv_unit. Each vector carries hand-computed
// HI/LO results and cycle counts; latencies follow MULDIV_EARLY_OUT_EN when
// the bench is built with that macro.
// ---------------------------------------------------------------------------
module tb_ex_muldiv_unit;

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EarlyOut = 1'b1;
`else
  localparam bit EarlyOut = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        inValid;
  logic [5:0]  inFunc;
  logic        inFlush;
  logic [31:0] opA;
  logic [31:0] opB;
  logic [31:0] mfData;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  int errorCount = 0;
  int checkCount = 0;

  ex_muldiv_unit dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (inValid),
    .in_func  (inFunc),
    .in_flush (inFlush),
    .op_a     (opA),
    .op_b     (opB),
    .mf_data  (mfData),
    .busy     (busy),
    .stall    (stall),
    .hi       (hi),
    .lo       (lo)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive the EX-side inputs for the coming edge.
  task automatic applyStimulus(input logic valid, input logic [5:0] func,
                               input logic flush, input logic [31:0] a,
                               input logic [31:0] b);
    inValid = valid;
    inFunc  = func;
    inFlush = flush;
    opA     = a;
    opB     = b;
  endtask

  // Advance one edge and settle 1 ns past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one multi-cycle op, count busy cycles (bounded), check results.
  task automatic runOp(input string tag, input logic [5:0] func,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] expHi, input logic [31:0] expLo,
                       input int expCycles);
    int cycles;
    applyStimulus(1'b1, func, 1'b0, a, b);
    tick();
    applyStimulus(1'b0, F_MFHI, 1'b0, 32'h0, 32'h0);
    cycles = 0;
    while (busy && cycles < 100) begin
      cycles++;
      tick();
    end
    checkOutput({tag, " cycles"}, 64'(cycles), 64'(expCycles));
    checkOutput({tag, " hi"}, 64'(hi), 64'(expHi));
    checkOutput({tag, " lo"}, 64'(lo), 64'(expLo));
  endtask

  // Hard time limit so the bench always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int cycles;

    reset = 1'b0;
    applyStimulus(1'b0, F_MFHI, 1'b0, 32'h0, 32'h0);
    #1;
    checkOutput("reset hi", 64'(hi), 64'h0);
    checkOutput("reset lo", 64'(lo), 64'h0);
    checkOutput("reset busy", 64'(busy), 64'h0);
    checkOutput("reset stall", 64'(stall), 64'h0);
    checkOutput("reset mf_data", 64'(mfData), 64'h0);
    tick();
    tick();
    reset = 1'b1;
    tick();

    // MTHI then MFHI in the next cycle
    applyStimulus(1'b1, F_MTHI, 1'b0, 32'h12345678, 32'h0);
    tick();
    applyStimulus(1'b1, F_MFHI, 1'b0, 32'h0, 32'h0);
    #1;
    checkOutput("mfhi data", 64'(mfData), 64'h12345678);
    checkOutput("mfhi stall", 64'(stall), 64'h0);
    checkOutput("mthi busy", 64'(busy), 64'h0);

    // MTLO then MFLO
    applyStimulus(1'b1, F_MTLO, 1'b0, 32'h0BADF00D, 32'h0);
    tick();
    applyStimulus(1'b1, F_MFLO, 1'b0, 32'h0, 32'h0);
    #1;
    checkOutput("mflo data", 64'(mfData), 64'h0BADF00D);

    // Flushed MULT: no issue, no stall, HI/LO untouched
    applyStimulus(1'b1, F_MULT, 1'b1, 32'h2, 32'h3);
    #1;
    checkOutput("flush stall", 64'(stall), 64'h0);
    tick();
    applyStimulus(1'b0, F_MFHI, 1'b0, 32'h0, 32'h0);
    checkOutput("flush busy", 64'(busy), 64'h0);
    tick();
    checkOutput("flush busy later", 64'(busy), 64'h0);
    checkOutput("flush hi", 64'(hi), 64'h12345678);
    checkOutput("flush lo", 64'(lo), 64'h0BADF00D);

    runOp("multu max", F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF,
          32'hFFFFFFFE, 32'h00000001, 32);

    // MULT -3 x 7 with MFLO held behind it from cycle T+1
    applyStimulus(1'b1, F_MULT, 1'b0, 32'hFFFFFFFD, 32'h7);
    tick();
    applyStimulus(1'b1, F_MFLO, 1'b0, 32'h0, 32'h0);
    #1;
    checkOutput("mult stall mf_data old", 64'(mfData), 64'h00000001);
    cycles = 0;
    while (stall && cycles < 100) begin
      cycles++;
      tick();
    end
    checkOutput("mult stall cycles", 64'(cycles), EarlyOut ? 64'd3 : 64'd32);
    checkOutput("mult mflo data", 64'(mfData), 64'hFFFFFFEB);
    checkOutput("mult hi", 64'(hi), 64'hFFFFFFFF);
    checkOutput("mult busy after", 64'(busy), 64'h0);
    applyStimulus(1'b0, F_MFHI, 1'b0, 32'h0, 32'h0);
    tick();

    runOp("mult minneg sq", F_MULT, 32'h80000000, 32'h80000000,
          32'h40000000, 32'h00000000, 32);
    runOp("div -7/2", F_DIV, 32'hFFFFFFF9, 32'h2,
          32'hFFFFFFFF, 32'hFFFFFFFD, 32);
    runOp("div 7/-2", F_DIV, 32'h7, 32'hFFFFFFFE,
          32'h00000001, 32'hFFFFFFFD, 32);
    runOp("divu 7/0", F_DIVU, 32'h7, 32'h0,
          32'h00000007, 32'hFFFFFFFF, EarlyOut ? 1 : 32);
    runOp("div -1/0", F_DIV, 32'hFFFFFFFF, 32'h0,
          32'hFFFFFFFF, 32'hFFFFFFFF, EarlyOut ? 1 : 32);
    runOp("div overflow", F_DIV, 32'h80000000, 32'hFFFFFFFF,
          32'h00000000, 32'h80000000, 32);
    runOp("divu big", F_DIVU, 32'hFFFFFFFF, 32'h00010000,
          32'h0000FFFF, 32'h0000FFFF, 32);

    // Flushed HI/LO op while busy must not stall
    applyStimulus(1'b1, F_DIVU, 1'b0, 32'd100, 32'd7);
    tick();
    applyStimulus(1'b1, F_MFHI, 1'b1, 32'h0, 32'h0);
    #1;
    checkOutput("busy flush stall", 64'(stall), 64'h0);
    checkOutput("busy flush busy", 64'(busy), 64'h1);
    applyStimulus(1'b0, F_MFHI, 1'b0, 32'h0, 32'h0);
    cycles = 0;
    while (busy && cycles < 100) begin
      cycles++;
      tick();
    end
    checkOutput("divu 100/7 lo", 64'(lo), 64'd14);
    checkOutput("divu 100/7 hi", 64'(hi), 64'd2);

    runOp("multu 5x1", F_MULTU, 32'h5, 32'h1,
          32'h0, 32'h5, EarlyOut ? 1 : 32);
    runOp("multu 5x0", F_MULTU, 32'h5, 32'h0,
          32'h0, 32'h0, EarlyOut ? 1 : 32);

    // Reset during a MULT at cycle T+10
    applyStimulus(1'b1, F_MULTU, 1'b0, 32'h00001234, 32'hFFFF5678);
    tick();
    applyStimulus(1'b0, F_MFHI, 1'b0, 32'h0, 32'h0);
    repeat (9) tick();
    checkOutput("pre-reset busy", 64'(busy), 64'h1);
    reset = 1'b0;
    #1;
    checkOutput("midop reset hi", 64'(hi), 64'h0);
    checkOutput("midop reset lo", 64'(lo), 64'h0);
    checkOutput("midop reset busy", 64'(busy), 64'h0);
    tick();
    reset = 1'b1;
    tick();
    applyStimulus(1'b1, F_MFLO, 1'b0, 32'h0, 32'h0);
    #1;
    checkOutput("post-reset mflo", 64'(mfData), 64'h0);
    applyStimulus(1'b0, F_MFHI, 1'b0, 32'h0, 32'h0);
    repeat (40) tick();
    checkOutput("post-reset busy", 64'(busy), 64'h0);
    checkOutput("post-reset hi", 64'(hi), 64'h0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Iterative multiply/divide unit in the EX stage, next to the ALU. It consumes the operands, register numbers and function code that the ID/EX register presents to EX.
- Owns the architectural HI/LO registers. Executes MULT/MULTU/DIV/DIVU over multiple cycles, MTHI/MTLO in one cycle, and serves MFHI/MFLO reads.
- Drives a stall request to the hazard unit. The request is asserted only when a HI/LO-dependent instruction reaches EX while a previous operation is still running.

Parameters:
- DATA_W, 32: operand and HI/LO width. Iteration count equals DATA_W.
- DIV0_LO, 32'hFFFFFFFF: value written to LO on divide-by-zero.

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-low reset (asserted at 0)
- in_valid  in  1  EX instruction is a HI/LO-class op (function code in MULT..MTLO set)
- in_func  in  6  ex_function_code: MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13, MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B
- in_flush  in  1  EX instruction is squashed this cycle; suppresses issue
- op_a  in  DATA_W  forwarded rs value (dividend/multiplicand/MTxx source)
- op_b  in  DATA_W  forwarded rt value (divisor/multiplier)
- mf_data  out  DATA_W  HI for MFHI, LO for MFLO, otherwise 0 (combinational)
- busy  out  1  multi-cycle operation in progress
- stall  out  1  hold IF/ID/EX, insert bubble into EX/MEM
- hi  out  DATA_W  HI register
- lo  out  DATA_W  LO register

Behaviour:
- Reset: state IDLE, hi=0, lo=0, iteration counter=0, internal accumulators=0. busy=0, stall=0, mf_data=0.
- FSM states:
  - IDLE: the only state that accepts an issue.
  - MUL: shift-add multiply. Unsigned magnitudes, one bit per cycle.
  - DIV: restoring divide. Unsigned magnitudes, one quotient bit per cycle.
- busy = (state != IDLE). stall = in_valid & busy & ~in_flush, purely combinational.
- Issue condition: edge where state==IDLE, in_valid=1 and in_flush=0.
  - MULT/MULTU/DIV/DIVU: latch magnitudes and sign flags (signed ops only), counter=0, go to MUL or DIV.
  - MTHI: hi<=op_a. MTLO: lo<=op_a. Both take one edge; state stays IDLE.
  - MFHI/MFLO: no state change. mf_data reflects the current hi/lo in the same cycle.
- Issued at edge T: one step per cycle; busy=1 for cycles T+1..T+DATA_W. At edge T+DATA_W: hi/lo written with sign fix-up, return to IDLE.
- Write at T+DATA_W:
  - MUL: {hi,lo} = 64-bit product. Negated if signs differ (MULT only).
  - DIV: lo = quotient, hi = remainder.
  - Signed DIV: quotient negative iff signs differ; remainder takes dividend's sign.
- The multi-cycle instruction itself never stalls; it leaves EX normally. Later non-HI/LO instructions are unaffected.
- in_valid arriving during the cycle of edge T+DATA_W still stalls (busy=1). It is accepted in the next cycle and sees the new hi/lo.
- in_valid with in_flush=1: no issue, no stall, hi/lo untouched.
- Boundary cases:
  - Divide-by-zero (op_b=0, DIV or DIVU): runs full latency. lo=DIV0_LO, hi=op_a unmodified (raw, no sign fix).
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. No trap.
- Reset asserted mid-operation aborts immediately to the reset state. Partial results are discarded.
- Edges with state!=IDLE never accept a new issue; the hazard unit guarantees the instruction is held via stall.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- Defined:
  - MUL finishes at the first edge after a step where the remaining multiplier-magnitude bits are all zero. Minimum 1 cycle; a multiplier of 0 or 1 completes at T+1.
  - DIV by zero completes at T+1 with the same hi/lo values as the full-latency path.
  - Results are bit-identical to the full-latency path.
- Undefined: fixed DATA_W-cycle latency for all MUL/DIV.

Test Plan:
- Reset low mid-MULT (cycle T+10) -> hi=lo=0, busy=0 immediately; after release, MFLO reads 0.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF issued at T -> busy cycles T+1..T+32; at T+32 hi=0xFFFFFFFE, lo=0x00000001.
- MULT -3 x 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. MFLO issued at T+1 -> stall high until T+32 inclusive, then mf_data=0xFFFFFFEB.
- DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7 / 0 -> lo=0xFFFFFFFF, hi=0x00000007.
- MTHI 0x12345678, then MFHI next cycle -> mf_data=0x12345678, stall=0.
- MULT with in_flush=1 -> no busy, hi/lo unchanged.
- With MULDIV_EARLY_OUT_EN, MULTU 5 x 1 -> busy only at T+1, lo=5.
